// File: rtl/gpu_pkg.sv
// Shared types and constants for the GPU pixel path.
// Contents: pixel_sink_state_e (flush FSM states), PIXEL_BYTES (bytes per pixel word).
package gpu_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } pixel_sink_state_e;

  localparam int unsigned PIXEL_BYTES = 2;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: rdata always presents the head entry while !empty.
// Ports: clock, reset_n (sync, active-low), push/wdata, pop/rdata, full, empty, count.
// Push while full and pop while empty are ignored.
module sync_fifo #(
  parameter  int unsigned WIDTH    = 8,
  parameter  int unsigned DEPTH    = 8,
  localparam int unsigned PTR_BITS = $clog2(DEPTH),
  localparam int unsigned CNT_BITS = $clog2(DEPTH + 1)
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                push,
  input  logic [WIDTH-1:0]    wdata,
  input  logic                pop,
  output logic [WIDTH-1:0]    rdata,
  output logic                full,
  output logic                empty,
  output logic [CNT_BITS-1:0] count
);

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [PTR_BITS-1:0] wr_ptr;
  logic [PTR_BITS-1:0] rd_ptr;
  logic                do_push;
  logic                do_pop;

  assign full    = (count == CNT_BITS'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_BITS'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_BITS'(1);
      count <= count + CNT_BITS'(do_push) - CNT_BITS'(do_pop);
    end
  end

endmodule

// File: rtl/pixel_sink.sv
// Avalon-MM write responder for the GPU pixel master: decodes byte addresses to
// (row, col), linearises to a framebuffer index, buffers in a FIFO and drains to
// a single-port SRAM write port. Supports a flush handshake before buffer swap.
// Ports: clock, reset_n (sync, active-low); s1_* Avalon slave (address, writedata,
// write, waitrequest); mem_* SRAM write port (addr, wdata, we, ready);
// flush_req/flush_done handshake; err_oob sticky flag with err_clear;
// accept_count/drop_count statistics.
// Build option: define PIXEL_SINK_STATS_EN to build the saturating counters;
// otherwise both count ports read as zero.
module pixel_sink
  import gpu_pkg::*;
#(
  parameter  int unsigned H_RESOLUTION = 320,
  parameter  int unsigned V_RESOLUTION = 240,
  parameter  int unsigned PIXEL_BITS   = 16,
  parameter  int unsigned FIFO_DEPTH   = 8,
  localparam int unsigned COL_BITS     = $clog2(H_RESOLUTION),
  localparam int unsigned ROW_BITS     = $clog2(V_RESOLUTION),
  localparam int unsigned IDX_BITS     = $clog2(H_RESOLUTION * V_RESOLUTION)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [31:0]           s1_address,
  input  logic [PIXEL_BITS-1:0] s1_writedata,
  input  logic                  s1_write,
  output logic                  s1_waitrequest,
  output logic [IDX_BITS-1:0]   mem_addr,
  output logic [PIXEL_BITS-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic                  mem_ready,
  input  logic                  flush_req,
  output logic                  flush_done,
  output logic                  err_oob,
  input  logic                  err_clear,
  output logic [31:0]           accept_count,
  output logic [31:0]           drop_count
);

  localparam int unsigned COL_LSB  = $clog2(PIXEL_BYTES);
  localparam int unsigned ROW_LSB  = COL_LSB + COL_BITS;
  localparam int unsigned FIFO_W   = IDX_BITS + PIXEL_BITS;
  localparam int unsigned CNT_BITS = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SUM_BITS = CNT_BITS + 1;

  pixel_sink_state_e state_q;

  logic                  ready_q;
  logic                  stage_valid;
  logic                  stage_oob;
  logic [ROW_BITS-1:0]   stage_row;
  logic [COL_BITS-1:0]   stage_col;
  logic [PIXEL_BITS-1:0] stage_data;

  logic [COL_BITS-1:0]   col_c;
  logic [ROW_BITS-1:0]   row_c;
  logic                  oob_c;
  logic                  accept;
  logic                  push;
  logic                  pop;
  logic [IDX_BITS-1:0]   stage_idx;
  logic [FIFO_W-1:0]     fifo_rdata;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_BITS-1:0]   fifo_count;
  logic [CNT_BITS-1:0]   fifo_count_d;
  logic                  pipe_empty_d;
  logic                  unused_addr;

  // Byte-lane bit and bits above the row field carry no pixel position.
  assign unused_addr = ^{s1_address[COL_LSB-1:0], s1_address[31:ROW_LSB+ROW_BITS]};

  // Address decode and range check of the incoming beat.
  assign col_c  = s1_address[COL_LSB +: COL_BITS];
  assign row_c  = s1_address[ROW_LSB +: ROW_BITS];
  assign oob_c  = (32'(col_c) >= H_RESOLUTION) || (32'(row_c) >= V_RESOLUTION);
  assign accept = s1_write && !s1_waitrequest;

  // Stall early enough that the stage register can always push next cycle.
  assign s1_waitrequest = !reset_n || !ready_q || (state_q == DRAIN) || fifo_full ||
                          ((SUM_BITS'(fifo_count) + SUM_BITS'(stage_valid)) >=
                           SUM_BITS'(FIFO_DEPTH - 1));

  assign stage_idx = IDX_BITS'(stage_row) * IDX_BITS'(H_RESOLUTION) + IDX_BITS'(stage_col);
  assign push      = stage_valid && !stage_oob;
  assign pop       = mem_we && mem_ready;

  assign mem_we    = !fifo_empty;
  assign mem_addr  = fifo_rdata[PIXEL_BITS +: IDX_BITS];
  assign mem_wdata = fifo_rdata[PIXEL_BITS-1:0];

  // Pipe occupancy after this edge; lets flush_done line up with the first empty cycle.
  assign fifo_count_d = fifo_count + CNT_BITS'(push) - CNT_BITS'(pop);
  assign pipe_empty_d = !accept && (fifo_count_d == '0);

  sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .wdata   ({stage_idx, stage_data}),
    .pop     (pop),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Stage register, error flag and flush FSM.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= RUN;
      flush_done  <= 1'b0;
      ready_q     <= 1'b0;
      err_oob     <= 1'b0;
      stage_valid <= 1'b0;
      stage_oob   <= 1'b0;
      stage_row   <= '0;
      stage_col   <= '0;
      stage_data  <= '0;
    end else begin
      ready_q     <= 1'b1;
      stage_valid <= accept;
      if (accept) begin
        stage_oob  <= oob_c;
        stage_row  <= row_c;
        stage_col  <= col_c;
        stage_data <= s1_writedata;
      end

      // Set has priority over clear.
      if (accept && oob_c) begin
        err_oob <= 1'b1;
      end else if (err_clear) begin
        err_oob <= 1'b0;
      end

      flush_done <= 1'b0;
      case (state_q)
        RUN: begin
          if (flush_req) begin
            state_q    <= DRAIN;
            flush_done <= pipe_empty_d;
          end
        end
        DRAIN: begin
          if (flush_done) begin
            state_q <= RUN;
          end else begin
            flush_done <= pipe_empty_d;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

`ifdef PIXEL_SINK_STATS_EN
  logic [31:0] accept_q;
  logic [31:0] drop_q;

  // Saturating statistics; cleared only by reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      accept_q <= '0;
      drop_q   <= '0;
    end else begin
      if (pop && (accept_q != 32'hFFFF_FFFF)) begin
        accept_q <= accept_q + 32'd1;
      end
      if (accept && oob_c && (drop_q != 32'hFFFF_FFFF)) begin
        drop_q <= drop_q + 32'd1;
      end
    end
  end

  assign accept_count = accept_q;
  assign drop_count   = drop_q;
`else
  assign accept_count = '0;
  assign drop_count   = '0;
`endif

endmodule

// File: tb/tb_pixel_sink.sv
// Directed testbench for pixel_sink (320x240, 16-bit pixels, FIFO depth 8).
// Inputs change 1 time unit after the rising edge; SRAM writes are logged on the falling edge.
module tb_pixel_sink;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] s1_address;
  logic [15:0] s1_writedata;
  logic        s1_write;
  logic        s1_waitrequest;
  logic [16:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic        mem_ready;
  logic        flush_req;
  logic        flush_done;
  logic        err_oob;
  logic        err_clear;
  logic [31:0] accept_count;
  logic [31:0] drop_count;

  int checks = 0;
  int errors = 0;

  logic [16:0] log_addr[$];
  logic [15:0] log_data[$];

  pixel_sink dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .s1_address     (s1_address),
    .s1_writedata   (s1_writedata),
    .s1_write       (s1_write),
    .s1_waitrequest (s1_waitrequest),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_we         (mem_we),
    .mem_ready      (mem_ready),
    .flush_req      (flush_req),
    .flush_done     (flush_done),
    .err_oob        (err_oob),
    .err_clear      (err_clear),
    .accept_count   (accept_count),
    .drop_count     (drop_count)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (reset_n && mem_we && mem_ready) begin
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_wdata);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] addr_of(input int unsigned row, input int unsigned col);
    return (32'(row) << 10) | (32'(col) << 1);
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
  endtask

  // Holds a write until accepted; returns one unit after the accepting edge.
  task automatic do_write(input logic [31:0] addr, input logic [15:0] data);
    logic w;
    logic done;
    done = 1'b0;
    s1_address   = addr;
    s1_writedata = data;
    s1_write     = 1'b1;
    for (int k = 0; k < 50 && !done; k++) begin
      w = s1_waitrequest;
      step();
      if (!w) done = 1'b1;
    end
    s1_write = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL write_timeout: addr %h never accepted", addr);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step();
    step();
    checks++; if (s1_waitrequest !== 1'b1) begin errors++; $display("FAIL reset_wait: got %b expected 1", s1_waitrequest); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", mem_we); end
    checks++; if (flush_done !== 1'b0 || err_oob !== 1'b0) begin errors++; $display("FAIL reset_flags: got fd=%b err=%b expected 0 0", flush_done, err_oob); end
    checks++; if (accept_count !== 32'd0 || drop_count !== 32'd0) begin errors++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", accept_count, drop_count); end
    reset_n = 1'b1;
    checks++; if (s1_waitrequest !== 1'b1) begin errors++; $display("FAIL post_reset_wait: got %b expected 1", s1_waitrequest); end
    step();
    checks++; if (s1_waitrequest !== 1'b0) begin errors++; $display("FAIL ready_wait: got %b expected 0", s1_waitrequest); end
  endtask

  task automatic test_single();
    mem_ready = 1'b1;
    clear_log();
    do_write(32'h0000_080A, 16'hF800);
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL single_t1_we: got %b expected 0", mem_we); end
    step();
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL single_t2_we: got %b expected 1", mem_we); end
    checks++; if (mem_addr !== 17'd645) begin errors++; $display("FAIL single_addr: got %0d expected 645", mem_addr); end
    checks++; if (mem_wdata !== 16'hF800) begin errors++; $display("FAIL single_data: got %h expected f800", mem_wdata); end
    repeat (4) step();
    checks++; if (log_addr.size() != 1) begin errors++; $display("FAIL single_count: got %0d writes expected 1", log_addr.size()); end
  endtask

  task automatic test_back_pressure();
    logic w;
    int   n_acc;
    mem_ready = 1'b0;
    clear_log();
    n_acc        = 0;
    s1_address   = addr_of(1, 0);
    s1_writedata = 16'h1000;
    s1_write     = 1'b1;
    for (int k = 0; k < 12; k++) begin
      w = s1_waitrequest;
      step();
      if (!w) begin
        n_acc++;
        s1_address   = addr_of(1, n_acc);
        s1_writedata = 16'h1000 + 16'(n_acc);
      end
    end
    s1_write = 1'b0;
    checks++; if (n_acc != 7) begin errors++; $display("FAIL bp_accepted: got %0d expected 7", n_acc); end
    checks++; if (s1_waitrequest !== 1'b1) begin errors++; $display("FAIL bp_stall: got %b expected 1", s1_waitrequest); end
    checks++; if (mem_we !== 1'b1 || mem_addr !== 17'd320) begin errors++; $display("FAIL bp_head: got we=%b addr=%0d expected 1 320", mem_we, mem_addr); end
    mem_ready = 1'b1;
    step();
    checks++; if (s1_waitrequest !== 1'b0) begin errors++; $display("FAIL bp_release: got %b expected 0", s1_waitrequest); end
    repeat (10) step();
    checks++; if (log_addr.size() != 7) begin errors++; $display("FAIL bp_drained: got %0d writes expected 7", log_addr.size()); end
    for (int i = 0; i < 7 && i < log_addr.size(); i++) begin
      checks++;
      if (log_addr[i] !== 17'(320 + i) || log_data[i] !== 16'h1000 + 16'(i)) begin
        errors++;
        $display("FAIL bp_order[%0d]: got %0d/%h expected %0d/%h", i, log_addr[i], log_data[i], 320 + i, 16'h1000 + 16'(i));
      end
    end
  endtask

  task automatic test_oob();
    mem_ready = 1'b1;
    clear_log();
    do_write(32'h0000_0280, 16'h1234);
    checks++; if (err_oob !== 1'b1) begin errors++; $display("FAIL oob_set: got %b expected 1", err_oob); end
    repeat (3) step();
    checks++; if (log_addr.size() != 0 || mem_we !== 1'b0) begin errors++; $display("FAIL oob_no_write: got %0d writes we=%b expected 0 0", log_addr.size(), mem_we); end
    // Clear and a new out-of-range beat in the same cycle: set wins.
    s1_address = addr_of(240, 0);
    s1_write   = 1'b1;
    err_clear  = 1'b1;
    checks++; if (s1_waitrequest !== 1'b0) begin errors++; $display("FAIL oob_wait: got %b expected 0", s1_waitrequest); end
    step();
    s1_write = 1'b0;
    checks++; if (err_oob !== 1'b1) begin errors++; $display("FAIL oob_set_wins: got %b expected 1", err_oob); end
    step();
    err_clear = 1'b0;
    checks++; if (err_oob !== 1'b0) begin errors++; $display("FAIL oob_clear: got %b expected 0", err_oob); end
    // Last in-range pixel of the frame.
    clear_log();
    do_write(addr_of(239, 319), 16'hABCD);
    repeat (3) step();
    checks++; if (log_addr.size() != 1 || log_addr[0] !== 17'd76799 || log_data[0] !== 16'hABCD) begin errors++; $display("FAIL last_pixel: got %0d writes expected 1 at 76799/abcd", log_addr.size()); end
    checks++; if (err_oob !== 1'b0) begin errors++; $display("FAIL last_pixel_err: got %b expected 0", err_oob); end
  endtask

  task automatic test_flush();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) do_write(addr_of(3, i), 16'h3000 + 16'(i));
    step();
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (s1_waitrequest !== 1'b1 || flush_done !== 1'b0) begin
        errors++;
        $display("FAIL flush_hold[%0d]: got wait=%b fd=%b expected 1 0", k, s1_waitrequest, flush_done);
      end
      step();
    end
    clear_log();
    mem_ready = 1'b1;
    step();
    checks++; if (flush_done !== 1'b0) begin errors++; $display("FAIL flush_early1: got %b expected 0", flush_done); end
    step();
    checks++; if (flush_done !== 1'b0) begin errors++; $display("FAIL flush_early2: got %b expected 0", flush_done); end
    step();
    checks++; if (flush_done !== 1'b1) begin errors++; $display("FAIL flush_done: got %b expected 1", flush_done); end
    checks++; if (log_addr.size() != 3 || log_addr[2] !== 17'd962) begin errors++; $display("FAIL flush_writes: got %0d writes expected 3 ending at 962", log_addr.size()); end
    step();
    checks++; if (flush_done !== 1'b0 || s1_waitrequest !== 1'b0) begin errors++; $display("FAIL flush_run: got fd=%b wait=%b expected 0 0", flush_done, s1_waitrequest); end
    // Flush with the pipe already empty completes in one cycle.
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    checks++; if (flush_done !== 1'b1 || s1_waitrequest !== 1'b1) begin errors++; $display("FAIL empty_flush: got fd=%b wait=%b expected 1 1", flush_done, s1_waitrequest); end
    step();
    checks++; if (flush_done !== 1'b0 || s1_waitrequest !== 1'b0) begin errors++; $display("FAIL empty_flush_end: got fd=%b wait=%b expected 0 0", flush_done, s1_waitrequest); end
  endtask

  task automatic test_reset_mid_drain();
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) do_write(addr_of(5, i), 16'h5000 + 16'(i));
    step();
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL pending_we: got %b expected 1", mem_we); end
    reset_n = 1'b0;
    step();
    checks++; if (mem_we !== 1'b0 || s1_waitrequest !== 1'b1) begin errors++; $display("FAIL mid_reset: got we=%b wait=%b expected 0 1", mem_we, s1_waitrequest); end
    reset_n   = 1'b1;
    mem_ready = 1'b1;
    clear_log();
    repeat (6) step();
    checks++; if (log_addr.size() != 0 || mem_we !== 1'b0) begin errors++; $display("FAIL stale_writes: got %0d writes we=%b expected 0 0", log_addr.size(), mem_we); end
  endtask

  task automatic test_stats();
    logic [31:0] exp_acc;
    logic [31:0] exp_drop;
`ifdef PIXEL_SINK_STATS_EN
    exp_acc  = 32'd4;
    exp_drop = 32'd2;
`else
    exp_acc  = 32'd0;
    exp_drop = 32'd0;
`endif
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    mem_ready = 1'b1;
    clear_log();
    for (int i = 0; i < 4; i++) do_write(addr_of(10, i), 16'hA000 + 16'(i));
    do_write(addr_of(0, 400), 16'hDEAD);
    do_write(addr_of(250, 0), 16'hBEEF);
    repeat (5) step();
    checks++; if (log_addr.size() != 4) begin errors++; $display("FAIL stats_writes: got %0d expected 4", log_addr.size()); end
    checks++; if (accept_count !== exp_acc) begin errors++; $display("FAIL accept_count: got %0d expected %0d", accept_count, exp_acc); end
    checks++; if (drop_count !== exp_drop) begin errors++; $display("FAIL drop_count: got %0d expected %0d", drop_count, exp_drop); end
    checks++; if (err_oob !== 1'b1) begin errors++; $display("FAIL stats_err: got %b expected 1", err_oob); end
  endtask

  initial begin
    reset_n      = 1'b0;
    s1_address   = '0;
    s1_writedata = '0;
    s1_write     = 1'b0;
    mem_ready    = 1'b0;
    flush_req    = 1'b0;
    err_clear    = 1'b0;
    test_reset();
    test_single();
    test_back_pressure();
    test_oob();
    test_flush();
    test_reset_mid_drain();
    test_stats();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
